// File: rtl/mem_pkg.sv
// Shared types for the two-requester sdp_ram arbiter: requester ids and
// the per-stage record carried through the read-response pipeline.
package mem_pkg;

    localparam int NREQ   = 2;
    localparam int NREQ_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef logic [NREQ_W-1:0] req_id_t;

    // One slot of the response pipeline: who gets the pulse and whether it is an error.
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    err;
    } resp_stage_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the requester that wins
// a tie; after a grant to requester k the pointer moves to the other one.
// The pointer only moves when i_advance is high, so a grant that is later
// vetoed (read/write collision) keeps its priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;

    // Grant the lone candidate, or the pointed-to one when both request.
    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // Hand priority to the other requester after every committed grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= 1'b0;
        end else if (i_advance && (|o_grant)) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Shares one simple-dual-port RAM (write port A, read port B) between the
// load/store unit (requester 0) and the loader (requester 1). Each port has
// its own round-robin arbiter; responses are routed back through a
// fixed-latency pipeline matching the RAM read latency.
module sdp_ram_arbiter
    import mem_pkg::*;
#(
    parameter int DATAW    = 32,
    parameter int ADDRW    = 32,
    parameter int WORD_LEN = 2,
    parameter int RD_LAT   = 1
) (
    input  logic             clk,
    input  logic             rstn,

    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic             req_we_0,
    input  logic [ADDRW-1:0] req_addr_0,
    input  logic [DATAW-1:0] req_wdata_0,
    output logic             resp_valid_0,
    output logic [DATAW-1:0] resp_rdata_0,
    output logic             resp_err_0,

    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic             req_we_1,
    input  logic [ADDRW-1:0] req_addr_1,
    input  logic [DATAW-1:0] req_wdata_1,
    output logic             resp_valid_1,
    output logic [DATAW-1:0] resp_rdata_1,
    output logic             resp_err_1,

    output logic             ram_wea,
    output logic [ADDRW-1:0] ram_addra,
    output logic [DATAW-1:0] ram_dina,
    output logic [ADDRW-1:0] ram_addrb,
    input  logic [DATAW-1:0] ram_doutb
);

    // Per-requester views of the request ports.
    logic [NREQ-1:0]  w_valid;
    logic [NREQ-1:0]  w_we;
    logic [NREQ-1:0]  w_mis;
    logic [ADDRW-1:0] w_addr  [NREQ];
    logic [DATAW-1:0] w_wdata [NREQ];

    assign w_valid    = {req_valid_1, req_valid_0};
    assign w_we       = {req_we_1, req_we_0};
    assign w_addr[0]  = req_addr_0;
    assign w_addr[1]  = req_addr_1;
    assign w_wdata[0] = req_wdata_0;
    assign w_wdata[1] = req_wdata_1;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mis
            assign w_mis[gi] = |w_addr[gi][WORD_LEN-1:0];
        end
    endgenerate

    // Arbitration: one arbiter per RAM port.
    logic [1:0] w_wcand, w_rcand, w_wgrant, w_rgrant;
    logic       w_coll;

    assign w_wcand = w_valid & w_we;
    assign w_rcand = w_valid & ~w_we;

    rr_arb2 u_wr_arb (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (w_wcand),
        .i_advance (1'b1),
        .o_grant   (w_wgrant)
    );

    rr_arb2 u_rd_arb (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (w_rcand),
        .i_advance (!w_coll),
        .o_grant   (w_rgrant)
    );

    // Winning requester on each port and its request fields.
    req_id_t          w_wid, w_rid;
    logic [ADDRW-1:0] w_waddr, w_raddr;
    logic [DATAW-1:0] w_wdat;
    logic             w_wmis, w_rmis, w_wany, w_rany_raw, w_rany;
    logic             w_wr_go, w_rd_go;

    assign w_wid      = req_id_t'(w_wgrant[1]);
    assign w_rid      = req_id_t'(w_rgrant[1]);
    assign w_waddr    = w_addr[w_wid];
    assign w_wdat     = w_wdata[w_wid];
    assign w_raddr    = w_addr[w_rid];
    assign w_wmis     = w_mis[w_wid];
    assign w_rmis     = w_mis[w_rid];
    assign w_wany     = |w_wgrant;
    assign w_rany_raw = |w_rgrant;

    // A same-word read would race the write, so it waits one cycle and then
    // observes the freshly written data.
    assign w_coll = w_wany && w_rany_raw && !w_wmis && !w_rmis &&
                    (w_waddr[ADDRW-1:WORD_LEN] == w_raddr[ADDRW-1:WORD_LEN]);
    assign w_rany = w_rany_raw && !w_coll;

    // Misaligned grants are accepted but never reach the RAM; nothing is
    // driven to the RAM while reset is held.
    assign w_wr_go = w_wany && !w_wmis && rstn;
    assign w_rd_go = w_rany && !w_rmis && rstn;

    assign req_ready_0 = w_wgrant[0] || (w_rgrant[0] && !w_coll);
    assign req_ready_1 = w_wgrant[1] || (w_rgrant[1] && !w_coll);

    // RAM address/data hold their last granted values between grants.
    logic [ADDRW-1:0] r_addra, r_addrb;
    logic [DATAW-1:0] r_dina;

    // Remember the last address/data actually presented to each RAM port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addra <= '0;
            r_dina  <= '0;
            r_addrb <= '0;
        end else begin
            if (w_wr_go) begin
                r_addra <= w_waddr;
                r_dina  <= w_wdat;
            end
            if (w_rd_go) begin
                r_addrb <= w_raddr;
            end
        end
    end

    assign ram_wea   = w_wr_go;
    assign ram_addra = w_wr_go ? w_waddr : r_addra;
    assign ram_dina  = w_wr_go ? w_wdat  : r_dina;
    assign ram_addrb = w_rd_go ? w_raddr : r_addrb;

    // Response pipeline. The read lane carries every read grant; the write
    // lane carries error responses for misaligned writes. Both can fill in
    // the same cycle because the two grants always go to different requesters.
    resp_stage_t r_pipe_rd [RD_LAT];
    resp_stage_t r_pipe_wr [RD_LAT];
    resp_stage_t w_push_rd, w_push_wr, w_out_rd, w_out_wr;

    // Build the entries entering the pipeline this cycle.
    always_comb begin
        w_push_rd       = '0;
        w_push_rd.valid = w_rany;
        w_push_rd.id    = w_rid;
        w_push_rd.err   = w_rmis;
        w_push_wr       = '0;
        w_push_wr.valid = w_wany && w_wmis;
        w_push_wr.id    = w_wid;
        w_push_wr.err   = 1'b1;
    end

    // Shift both lanes one stage per cycle; reset drops anything in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < RD_LAT; s++) begin
                r_pipe_rd[s] <= '0;
                r_pipe_wr[s] <= '0;
            end
        end else begin
            r_pipe_rd[0] <= w_push_rd;
            r_pipe_wr[0] <= w_push_wr;
            for (int s = 1; s < RD_LAT; s++) begin
                r_pipe_rd[s] <= r_pipe_rd[s-1];
                r_pipe_wr[s] <= r_pipe_wr[s-1];
            end
        end
    end

    assign w_out_rd = r_pipe_rd[RD_LAT-1];
    assign w_out_wr = r_pipe_wr[RD_LAT-1];

    // Route the final stage to the requester it belongs to.
    logic [NREQ-1:0]  w_resp_valid, w_resp_err;
    logic [DATAW-1:0] w_resp_rdata [NREQ];

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_resp
            logic w_rd_hit, w_wr_hit;
            assign w_rd_hit          = w_out_rd.valid && (w_out_rd.id == req_id_t'(gi));
            assign w_wr_hit          = w_out_wr.valid && (w_out_wr.id == req_id_t'(gi));
            assign w_resp_valid[gi]  = w_rd_hit || w_wr_hit;
            assign w_resp_err[gi]    = (w_rd_hit && w_out_rd.err) || (w_wr_hit && w_out_wr.err);
            assign w_resp_rdata[gi]  = (w_rd_hit && !w_out_rd.err) ? ram_doutb : '0;
        end
    endgenerate

    assign resp_valid_0 = w_resp_valid[0];
    assign resp_err_0   = w_resp_err[0];
    assign resp_rdata_0 = w_resp_rdata[0];
    assign resp_valid_1 = w_resp_valid[1];
    assign resp_err_1   = w_resp_err[1];
    assign resp_rdata_1 = w_resp_rdata[1];

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Bench for sdp_ram_arbiter with a behavioural sdp_ram (2-cycle read latency)
// and a per-requester scoreboard of expected responses.
module tb_sdp_ram_arbiter;

    localparam int DATAW    = 32;
    localparam int ADDRW    = 32;
    localparam int WORD_LEN = 2;
    localparam int RD_LAT   = 2;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        v0, we0, v1, we1;
    logic [31:0] a0, d0, a1, d1;
    logic        req_ready_0, req_ready_1;
    logic        resp_valid_0, resp_valid_1, resp_err_0, resp_err_1;
    logic [31:0] resp_rdata_0, resp_rdata_1;
    logic        ram_wea;
    logic [31:0] ram_addra, ram_dina, ram_addrb, ram_doutb;

    sdp_ram_arbiter #(
        .DATAW    (DATAW),
        .ADDRW    (ADDRW),
        .WORD_LEN (WORD_LEN),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid_0  (v0),
        .req_ready_0  (req_ready_0),
        .req_we_0     (we0),
        .req_addr_0   (a0),
        .req_wdata_0  (d0),
        .resp_valid_0 (resp_valid_0),
        .resp_rdata_0 (resp_rdata_0),
        .resp_err_0   (resp_err_0),
        .req_valid_1  (v1),
        .req_ready_1  (req_ready_1),
        .req_we_1     (we1),
        .req_addr_1   (a1),
        .req_wdata_1  (d1),
        .resp_valid_1 (resp_valid_1),
        .resp_rdata_1 (resp_rdata_1),
        .resp_err_1   (resp_err_1),
        .ram_wea      (ram_wea),
        .ram_addra    (ram_addra),
        .ram_dina     (ram_dina),
        .ram_addrb    (ram_addrb),
        .ram_doutb    (ram_doutb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'hFF);
    endfunction

    // Behavioural sdp_ram: write on A, registered read plus output register on B.
    logic [31:0] ram_mem [0:255];
    logic [31:0] rd1, rd2;
    always @(posedge clk) begin
        rd1 <= ram_mem[widx(ram_addrb)];
        rd2 <= rd1;
        if (ram_wea) ram_mem[widx(ram_addra)] <= ram_dina;
    end
    assign ram_doutb = rd2;

    // Reference memory and scoreboard.
    logic [31:0] ref_mem [0:255];
    exp_t q0[$];
    exp_t q1[$];
    logic no_push = 1'b0;
    int   resp_seen = 0;

    // Sampled state of the most recent step.
    logic        s_rdy0, s_rdy1, s_wea;
    logic [31:0] s_addra, s_dina, s_addrb;

    task automatic commit(input int k, input logic we, input logic [31:0] a, input logic [31:0] d);
        logic mis;
        exp_t e;
        mis = ((a & 32'h3) != 0);
        if (we && !mis) begin
            ref_mem[widx(a)] = d;
        end else if (!no_push) begin
            e.err  = mis;
            e.data = (mis || we) ? 32'h0 : ref_mem[widx(a)];
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    // Sample the cycle's grants mid-cycle, record accepted requests, move to next cycle.
    task automatic step();
        @(negedge clk);
        s_rdy0  = req_ready_0;
        s_rdy1  = req_ready_1;
        s_wea   = ram_wea;
        s_addra = ram_addra;
        s_dina  = ram_dina;
        s_addrb = ram_addrb;
        if (rstn) begin
            if (v0 && s_rdy0) commit(0, we0, a0, d0);
            if (v1 && s_rdy1) commit(1, we1, a1, d1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        v0 = v; we0 = we; a0 = a; d0 = d;
    endtask

    task automatic set1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
        v1 = v; we1 = we; a1 = a; d1 = d;
    endtask

    task automatic idle(input int n);
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    // Response monitor: every pulse must match the oldest expectation of its requester.
    task automatic mon_resp(input int k, input logic [31:0] d, input logic e);
        exp_t x;
        resp_seen++;
        if (k == 0) begin
            if (q0.size() == 0) begin
                check_val("r0_unexpected_resp", 1, 0);
                return;
            end
            x = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin
                check_val("r1_unexpected_resp", 1, 0);
                return;
            end
            x = q1.pop_front();
        end
        $display("RESP r%0d data=%08h err=%0d exp_data=%08h exp_err=%0d", k, d, e, x.data, x.err);
        check_val($sformatf("r%0d_rdata", k), {32'h0, d}, {32'h0, x.data});
        check_val($sformatf("r%0d_err", k), {63'h0, e}, {63'h0, x.err});
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (resp_valid_0) mon_resp(0, resp_rdata_0, resp_err_0);
            if (resp_valid_1) mon_resp(1, resp_rdata_1, resp_err_1);
        end
    end

    initial begin
        int seen_before;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        rstn = 1'b0;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_wea",    {63'h0, ram_wea}, 0);
        check_val("rst_addra",  {32'h0, ram_addra}, 0);
        check_val("rst_dina",   {32'h0, ram_dina}, 0);
        check_val("rst_addrb",  {32'h0, ram_addrb}, 0);
        check_val("rst_resp_v", {62'h0, resp_valid_1, resp_valid_0}, 0);
        rstn = 1'b1;

        // Write then read back on requester 0.
        set0(1, 1, 32'h40, 32'hDEADBEEF);
        step();
        check_val("wr40_ready", {63'h0, s_rdy0}, 1);
        check_val("wr40_wea",   {63'h0, s_wea}, 1);
        check_val("wr40_addra", {32'h0, s_addra}, 32'h40);
        check_val("wr40_dina",  {32'h0, s_dina}, 32'hDEADBEEF);
        set0(1, 0, 32'h40, 0);
        step();
        check_val("rd40_ready", {63'h0, s_rdy0}, 1);
        check_val("rd40_addrb", {32'h0, s_addrb}, 32'h40);
        idle(1);
        check_val("idle_wea",   {63'h0, s_wea}, 0);
        check_val("idle_addra", {32'h0, s_addra}, 32'h40);

        // Seed words 0x0 and 0x4 with distinct values for the routing test.
        set0(1, 1, 32'h0, 32'hA0A0A0A0);
        step();
        set0(0, 0, 0, 0);
        set1(1, 1, 32'h4, 32'hB1B1B1B1);
        step();
        check_val("wr4_ready", {63'h0, s_rdy1}, 1);
        idle(4);

        // Fresh reset, then both requesters read continuously: strict alternation from r0.
        do_reset();
        set0(1, 0, 32'h0, 0);
        set1(1, 0, 32'h4, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_val($sformatf("alt%0d_rdy0", i), {63'h0, s_rdy0}, {63'h0, (i % 2) == 0});
            check_val($sformatf("alt%0d_rdy1", i), {63'h0, s_rdy1}, {63'h0, (i % 2) == 1});
        end
        idle(4);

        // Same-word write/read collision: read deferred one cycle, returns new data.
        set0(1, 1, 32'h80, 32'h1234);
        set1(1, 0, 32'h80, 0);
        step();
        check_val("coll_rdy0", {63'h0, s_rdy0}, 1);
        check_val("coll_rdy1", {63'h0, s_rdy1}, 0);
        check_val("coll_wea",  {63'h0, s_wea}, 1);
        set0(0, 0, 0, 0);
        step();
        check_val("coll_retry_rdy1", {63'h0, s_rdy1}, 1);
        idle(4);

        // Different-word write and read issue together.
        set0(1, 1, 32'h10, 32'h5555AAAA);
        set1(1, 0, 32'h20, 0);
        step();
        check_val("dual_rdy0",  {63'h0, s_rdy0}, 1);
        check_val("dual_rdy1",  {63'h0, s_rdy1}, 1);
        check_val("dual_wea",   {63'h0, s_wea}, 1);
        check_val("dual_addra", {32'h0, s_addra}, 32'h10);
        check_val("dual_addrb", {32'h0, s_addrb}, 32'h20);

        // Misaligned read: accepted, RAM read port untouched, error response.
        set0(0, 0, 0, 0);
        set1(1, 0, 32'h41, 0);
        step();
        check_val("misrd_rdy1",  {63'h0, s_rdy1}, 1);
        check_val("misrd_addrb", {32'h0, s_addrb}, 32'h20);

        // Misaligned write: accepted, no RAM write, error response.
        set1(0, 0, 0, 0);
        set0(1, 1, 32'h42, 32'hFFFFFFFF);
        step();
        check_val("miswr_rdy0", {63'h0, s_rdy0}, 1);
        check_val("miswr_wea",  {63'h0, s_wea}, 0);
        idle(4);

        // Reset one cycle after a read grant drops the response.
        no_push = 1'b1;
        set0(1, 0, 32'h40, 0);
        step();
        check_val("drop_rdy0", {63'h0, s_rdy0}, 1);
        no_push = 1'b0;
        set0(0, 0, 0, 0);
        seen_before = resp_seen;
        rstn = 1'b0;
        @(negedge clk);
        check_val("drop_resp_v0", {63'h0, resp_valid_0}, 0);
        check_val("drop_addrb",   {32'h0, ram_addrb}, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(4);
        check_val("drop_no_resp", resp_seen - seen_before, 0);

        // After reset both arbiters favour requester 0.
        set0(1, 0, 32'h80, 0);
        set1(1, 0, 32'h4, 0);
        step();
        check_val("post_rd_rdy0", {63'h0, s_rdy0}, 1);
        check_val("post_rd_rdy1", {63'h0, s_rdy1}, 0);
        set0(1, 1, 32'h100, 32'h11111111);
        set1(1, 1, 32'h104, 32'h22222222);
        step();
        check_val("post_wr_rdy0", {63'h0, s_rdy0}, 1);
        check_val("post_wr_rdy1", {63'h0, s_rdy1}, 0);
        set0(0, 0, 0, 0);
        step();
        check_val("post_wr1_rdy1", {63'h0, s_rdy1}, 1);
        set1(1, 0, 32'h104, 0);
        step();
        check_val("rd104_rdy1", {63'h0, s_rdy1}, 1);
        idle(6);

        check_val("q0_drained", q0.size(), 0);
        check_val("q1_drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety net against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdp_ram_arbiter.md
# sdp_ram_arbiter

Two-requester arbiter that shares one `sdp_ram` instance (1 write port A, 1 read port B) between the core load/store unit (requester 0) and the program/data loader (requester 1). Write and read ports are arbitrated independently with round-robin priority. A read and a write from different requesters can issue in the same cycle. The block tracks in-flight reads through a fixed-latency response pipeline and routes `doutb` back to the issuing requester. It sits between the memory-stage/loader logic and `sdp_ram`.

## Interface
- `DATAW`, 32, data word width
- `ADDRW`, 32, byte-address width (the same address is forwarded to `sdp_ram`)
- `WORD_LEN`, 2, log2 of bytes per word; the low `WORD_LEN` address bits must be zero
- `RD_LAT`, 1, `sdp_ram` read latency in cycles (1 = no output register, 2 = output register)

Ports (`i` ∈ {0,1}):
- `clk`  in  1  single clock; everything is rising-edge
- `rstn`  in  1  asynchronous, active-low reset
- `req_valid_i`  in  1  request present
- `req_ready_i`  out  1  request accepted this cycle (combinational from valids, pointers and collision check)
- `req_we_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  ADDRW  byte address
- `req_wdata_i`  in  DATAW  write data
- `resp_valid_i`  out  1  read data / error valid; one-cycle pulse with no backpressure
- `resp_rdata_i`  out  DATAW  read data
- `resp_err_i`  out  1  misaligned request flag, qualified by `resp_valid_i`
- `ram_wea`  out  1  to `sdp_ram.wea`
- `ram_addra`  out  ADDRW  to `sdp_ram.addra`
- `ram_dina`  out  DATAW  to `sdp_ram.dina`
- `ram_addrb`  out  ADDRW  to `sdp_ram.addrb`
- `ram_doutb`  in  DATAW  from `sdp_ram.doutb`

## Operation
- **Write port.** Candidates are requesters with `valid && we`.
  - One candidate: it is granted.
  - Two candidates: the one pointed to by `wptr` is granted.
  - After a grant to requester k, `wptr` moves to 1-k.
  - Grant drives `ram_wea=1` with that requester's `addr`/`wdata`. Otherwise `ram_wea=0` and `ram_addra`/`ram_dina` hold the last granted values.
- **Read port.** Candidates are requesters with `valid && !we`. Selection uses `rptr` with the same rule as the write port.
  - Grant drives `ram_addrb` and pushes {valid, id, err=0} into the response pipeline.
- **Misaligned request** (`addr[WORD_LEN-1:0]!=0`, read or write):
  - It takes part in arbitration normally.
  - When granted, it is accepted (`req_ready=1`) but does not touch the RAM (no `wea`, no `addrb` change).
  - It pushes {valid, id, err=1} into the response pipeline. A misaligned write therefore also produces a response pulse.
- **Collision.** If the write grant and read grant in the same cycle target the same word (`addr[ADDRW-1:WORD_LEN]` equal, both aligned):
  - The read is not granted; its `req_ready=0` and `rptr` is unchanged.
  - The write proceeds.
  - The read wins the next cycle if still presented and will return the new data.
- A requester presenting one request is never granted on both ports in one cycle.
- **Response pipeline:** `RD_LAT` stages of {valid, id, err}. Stage `RD_LAT-1` drives the addressed requester's `resp_valid`, with `resp_rdata=ram_doutb` (0 when err).
- **Reset** (asynchronous, any time):
  - `wptr=rptr=0`.
  - Pipeline cleared, so in-flight reads are dropped and no `resp_valid` is produced for them.
  - `ram_wea=0`, `ram_addra=ram_addrb=0`, `ram_dina=0`.
  - All `resp_*` outputs = 0.
  - `req_ready` follows its combinational rule.

## Timing
- Write: granted at edge t, so the RAM is written at edge t (`wea` is combinational in the grant cycle). A read granted in cycle t+1 or later sees the new data.
- Read: granted in cycle t, so `resp_valid`/`resp_rdata` are valid in cycle t+`RD_LAT`.
- Error response: also arrives at t+`RD_LAT`, which keeps responses in order per requester.
- Throughput: one read plus one write per cycle. Back-to-back grants to the same requester are allowed when the other requester is idle.
- Requesters must hold `valid`/`we`/`addr`/`wdata` stable until `ready`.

## Structure
- Shared package `mem_pkg`: requester count constant (`NREQ=2`), requester id typedef, and the response-stage struct {valid, id, err}.
- Sub-module `rr_arb2`: 2-input round-robin arbiter with pointer register, `grant[1:0]` and an `advance` input. It is instantiated twice (write port, read port). The read-port `advance` is gated by the collision check.
- Response pipeline and collision compare live in the top module.

## Test plan
- Reset, then r0 writes 0xDEADBEEF to 0x40; next cycle r0 reads 0x40 → `resp_valid_0` at +`RD_LAT` with 0xDEADBEEF, `resp_err_0=0`.
- Both requesters issue continuous reads (r0 0x0, r1 0x4) → grants alternate 0,1,0,1, starting with r0; each gets 50% of the read port, and responses are routed to the correct id.
- r0 writes 0x80 = 0x1234 while r1 reads 0x80 in the same cycle → r1 `ready=0` that cycle, granted next cycle, returns 0x1234.
- r0 writes 0x10 and r1 reads 0x20 in the same cycle → both ready, `ram_wea=1` and `ram_addrb=0x20` in the same cycle.
- r1 reads 0x41 → accepted, `ram_addrb` unchanged, `resp_valid_1=1`, `resp_err_1=1`, `resp_rdata_1=0` at +`RD_LAT`.
- With `RD_LAT=2`, assert `rstn=0` one cycle after a read grant → no `resp_valid` ever appears for that read; after release, both pointers favour r0.
